// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and its active-low 7-segment decoder.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Decimal digits of 2**bin_w-1 is floor(bin_w*log10(2))+1
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin_bcd_seq_disp_seg7_decoder.sv
// One BCD nibble to an active-low 7-segment pattern; non-decimal codes go blank.
module seg7_decoder
  import bin_bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (nibble <= 4'd9) begin
      seg = SEG_DIGIT[nibble];
    end
  end

endmodule

// File: rtl/bin_bcd_seq_disp.sv
// Sequential double-dabble binary-to-BCD converter with multi-digit 7-segment drive.
// Define BIN_BCD_LZ_BLANK_EN to blank leading zero digits on seg_out.
module bin_bcd_seq_disp
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
    $error("bin_bcd_seq_disp: DIGITS too small for BIN_W");
  end

  // Handshake: start is sampled only in IDLE; busy is high from the cycle after
  // the accepting edge through the done cycle; done is a one-cycle pulse that
  // coincides with the new bcd_out/seg_out.
  state_e             state_q, state_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [SCR_W-1:0]   scr_adj;
  logic [7*DIGITS-1:0] seg_raw;

  // Add-3 correction per nibble, no carry between nibbles
  always_comb begin
    scr_adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[BIN_W+4*k +: 4] >= 4'd5) begin
        scr_adj[BIN_W+4*k +: 4] = scr_q[BIN_W+4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    busy_d  = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          scr_d   = {{BCD_W{1'b0}}, bin_in};
          cnt_d   = CNT_W'(BIN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d = {scr_adj[SCR_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = scr_q[SCR_W-1:BIN_W];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .nibble (bcd_q[4*g +: 4]),
      .seg    (seg_raw[7*g +: 7])
    );
  end

`ifdef BIN_BCD_LZ_BLANK_EN
  logic lz_lead;

  // Walk from the top digit down; blank while still in the leading-zero run
  always_comb begin
    lz_lead = 1'b1;
    seg_out = seg_raw;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (k != 0 && lz_lead && bcd_q[4*k +: 4] == 4'd0) begin
        seg_out[7*k +: 7] = SEG_BLANK;
      end else begin
        lz_lead = 1'b0;
      end
    end
  end
`else
  assign seg_out = seg_raw;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_bcd_seq_disp.sv
// Directed bench for bin_bcd_seq_disp (BIN_W=8, DIGITS=3); follows BIN_BCD_LZ_BLANK_EN.
module tb_bin_bcd_seq_disp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [20:0] seg_out;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  int          lat, busy_n, hold_err, cnt;
  logic [11:0] prev, e;

`ifdef BIN_BCD_LZ_BLANK_EN
  localparam logic [20:0] SEG_RST = {7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [20:0] SEG_99  = {7'b1111111, 7'b0010000, 7'b0010000};
  localparam logic [20:0] SEG_42  = {7'b1111111, 7'b0011001, 7'b0100100};
`else
  localparam logic [20:0] SEG_RST = {7'b1000000, 7'b1000000, 7'b1000000};
  localparam logic [20:0] SEG_99  = {7'b1000000, 7'b0010000, 7'b0010000};
  localparam logic [20:0] SEG_42  = {7'b1000000, 7'b0011001, 7'b0100100};
`endif
  localparam logic [20:0] SEG_255 = {7'b0100100, 7'b0010010, 7'b0010010};
  localparam logic [20:0] SEG_100 = {7'b1111001, 7'b1000000, 7'b1000000};

  always #5 clk = ~clk;

  bin_bcd_seq_disp #(.BIN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .seg_out (seg_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] ref_seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] ref_seg(input logic [11:0] b);
    logic [20:0] s;
    s = {ref_seg7(b[11:8]), ref_seg7(b[7:4]), ref_seg7(b[3:0])};
`ifdef BIN_BCD_LZ_BLANK_EN
    if (b[11:8] == 4'd0) s[20:14] = 7'b1111111;
    if (b[11:4] == 8'd0) s[13:7]  = 7'b1111111;
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one start, optionally pokes a second start at loop cycle inj_cycle,
  // and returns once done is seen (or after a 20-cycle bound).
  task automatic run_conv(input logic [7:0] v, input int inj_cycle, input logic [7:0] inj_val,
                          input logic [11:0] prv, output int lat_o, output int busy_o,
                          output int hold_o);
    start  = 1'b1;
    bin_in = v;
    tick();
    start  = 1'b0;
    bin_in = 8'($urandom_range(0, 255));
    lat_o  = 0;
    busy_o = 0;
    hold_o = 0;
    if (busy) busy_o++;
    if (bcd_out !== prv) hold_o++;
    while (lat_o < 20) begin
      tick();
      lat_o++;
      if (lat_o == inj_cycle) begin
        start  = 1'b1;
        bin_in = inj_val;
      end else begin
        start  = 1'b0;
        bin_in = 8'($urandom_range(0, 255));
      end
      if (busy) busy_o++;
      if (done) break;
      if (bcd_out !== prv) hold_o++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h000);
    chk("rst_seg", 32'(seg_out), 32'(SEG_RST));
    rst = 1'b0;
    tick();
    chk("idle_bcd", 32'(bcd_out), 32'h000);
    chk("idle_busy", 32'(busy), 32'd0);

    run_conv(8'd255, 0, 8'd0, 12'h000, lat, busy_n, hold_err);
    chk("lat_255", 32'(lat), 32'd9);
    chk("busy_255", 32'(busy_n), 32'd9);
    chk("hold_255", 32'(hold_err), 32'd0);
    chk("bcd_255", 32'(bcd_out), 32'h255);
    chk("seg_255", 32'(seg_out), 32'(SEG_255));
    tick();
    chk("done_pulse_255", 32'(done), 32'd0);
    chk("busy_after_255", 32'(busy), 32'd0);
    chk("bcd_keep_255", 32'(bcd_out), 32'h255);

    run_conv(8'd99, 3, 8'd7, 12'h255, lat, busy_n, hold_err);
    chk("lat_99", 32'(lat), 32'd9);
    chk("hold_99", 32'(hold_err), 32'd0);
    chk("bcd_99", 32'(bcd_out), 32'h099);
    chk("seg_99", 32'(seg_out), 32'(SEG_99));
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || done) cnt++;
    end
    chk("no_queue_99", 32'(cnt), 32'd0);

    run_conv(8'd42, 0, 8'd0, 12'h099, lat, busy_n, hold_err);
    chk("bcd_42", 32'(bcd_out), 32'h042);
    chk("seg_42", 32'(seg_out), 32'(SEG_42));
    tick();
    chk("done_pulse_42", 32'(done), 32'd0);
    run_conv(8'd100, 0, 8'd0, 12'h042, lat, busy_n, hold_err);
    chk("lat_100", 32'(lat), 32'd9);
    chk("hold_100", 32'(hold_err), 32'd0);
    chk("bcd_100", 32'(bcd_out), 32'h100);
    chk("seg_100", 32'(seg_out), 32'(SEG_100));
    tick();

    start  = 1'b1;
    bin_in = 8'd200;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("busy_mid_200", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'h000);
    chk("abort_seg", 32'(seg_out), 32'(SEG_RST));
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy || done) cnt++;
    end
    chk("abort_quiet", 32'(cnt), 32'd0);

    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 8'd77;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy || done) cnt++;
    end
    chk("rst_beats_start", 32'(cnt), 32'd0);
    chk("rst_start_bcd", 32'(bcd_out), 32'h000);

    prev = 12'h000;
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(ref_bcd(v));
      run_conv(8'(v), 0, 8'd0, prev, lat, busy_n, hold_err);
      e = exp_q.pop_front();
      chk($sformatf("sweep_lat_%0d", v), 32'(lat), 32'd9);
      chk($sformatf("sweep_bcd_%0d", v), 32'(bcd_out), 32'(e));
      chk($sformatf("sweep_seg_%0d", v), 32'(seg_out), 32'(ref_seg(e)));
      chk($sformatf("sweep_hold_%0d", v), 32'(hold_err), 32'd0);
      prev = e;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
